// File: rtl/dmem_pkg.sv
// Shared definitions for the DataMemory arbiter: default widths, FSM state
// encoding and requester port indices.
package dmem_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. On a tie the port that did not win
// last time is granted; a lone requester always wins.
module rr_arbiter2
  import dmem_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic grant_o,
  output logic grant_valid_o
);

  always_comb begin
    grant_valid_o = req0_i | req1_i;
    grant_o       = PORT0;
    if (req0_i && req1_i) begin
      grant_o = ~last_grant_i;
    end else if (req1_i) begin
      grant_o = PORT1;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares a single-port DataMemory between two requesters: round-robin grant,
// one access at a time, registered strobes and a one-cycle acknowledge.
module data_memory_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_data_inputs,
  input  logic [DATA_W-1:0] mem_data_outputs
);

  // Counter holds the remaining wait cycles after the strobe edge (MEM_LAT 1..4).
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT - 1);

  state_e              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic                we_q, we_d;
  logic [1:0]          lat_cnt_q, lat_cnt_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   mem_address_q, mem_address_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

  logic                arb_grant;
  logic                arb_valid;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  rr_arbiter2 u_arb (
    .req0_i        (req0),
    .req1_i        (req1),
    .last_grant_i  (last_grant_q),
    .grant_o       (arb_grant),
    .grant_valid_o (arb_valid)
  );

  assign sel_we    = (arb_grant == PORT1) ? we1    : we0;
  assign sel_addr  = (arb_grant == PORT1) ? addr1  : addr0;
  assign sel_wdata = (arb_grant == PORT1) ? wdata1 : wdata0;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    we_d          = we_q;
    lat_cnt_d     = lat_cnt_q;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d       = arb_grant;
          we_d          = sel_we;
          mem_address_d = sel_addr;
          mem_wdata_d   = sel_wdata;
          mem_write_d   = sel_we;
          mem_read_d    = ~sel_we;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
          ack0_d  = (grant_q == PORT0);
          ack1_d  = (grant_q == PORT1);
        end else begin
          state_d   = WAIT;
          lat_cnt_d = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_cnt_q != 2'd0) begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end else begin
          if (grant_q == PORT1) begin
            rdata1_d = mem_data_outputs;
          end else begin
            rdata0_d = mem_data_outputs;
          end
          state_d = DONE;
          ack0_d  = (grant_q == PORT0);
          ack1_d  = (grant_q == PORT1);
        end
      end
      DONE: begin
        state_d      = IDLE;
        last_grant_d = grant_q;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= PORT0;
      last_grant_q  <= PORT1;
      we_q          <= 1'b0;
      lat_cnt_q     <= 2'd0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      busy_q        <= 1'b0;
      mem_address_q <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      we_q          <= we_d;
      lat_cnt_q     <= lat_cnt_d;
      ack0_q        <= ack0_d;
      ack1_q        <= ack1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      busy_q        <= busy_d;
      mem_address_q <= mem_address_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign ack0            = ack0_q;
  assign ack1            = ack1_q;
  assign rdata0          = rdata0_q;
  assign rdata1          = rdata1_q;
  assign busy            = busy_q;
  assign mem_address     = mem_address_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_data_inputs = mem_wdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed vectors, held-request arbitration,
// reset mid-read, a MEM_LAT=3 build and randomized traffic against a model.
module tb_data_memory_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // DUT A: MEM_LAT = 1
  logic [1:0] req_a, we_a, ack_a;
  logic [7:0] addr_a [2];
  logic [7:0] wdata_a [2];
  logic [7:0] rdata_a [2];
  logic       busy_a, mrd_a, mwr_a;
  logic [7:0] maddr_a, mdin_a, mdout_a;
  logic [7:0] mem_a [256];

  // DUT B: MEM_LAT = 3
  logic [1:0] req_b, we_b, ack_b;
  logic [7:0] addr_b [2];
  logic [7:0] wdata_b [2];
  logic [7:0] rdata_b [2];
  logic       busy_b, mrd_b, mwr_b;
  logic [7:0] maddr_b, mdin_b, mdout_b;
  logic [7:0] mem_b [256];
  logic [7:0] val_b;
  logic [1:0] pend_b;

  data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req_a[0]), .req1(req_a[1]), .we0(we_a[0]), .we1(we_a[1]),
    .addr0(addr_a[0]), .addr1(addr_a[1]), .wdata0(wdata_a[0]), .wdata1(wdata_a[1]),
    .ack0(ack_a[0]), .ack1(ack_a[1]), .rdata0(rdata_a[0]), .rdata1(rdata_a[1]),
    .busy(busy_a), .mem_address(maddr_a), .mem_read(mrd_a), .mem_write(mwr_a),
    .mem_data_inputs(mdin_a), .mem_data_outputs(mdout_a)
  );

  data_memory_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .req0(req_b[0]), .req1(req_b[1]), .we0(we_b[0]), .we1(we_b[1]),
    .addr0(addr_b[0]), .addr1(addr_b[1]), .wdata0(wdata_b[0]), .wdata1(wdata_b[1]),
    .ack0(ack_b[0]), .ack1(ack_b[1]), .rdata0(rdata_b[0]), .rdata1(rdata_b[1]),
    .busy(busy_b), .mem_address(maddr_b), .mem_read(mrd_b), .mem_write(mwr_b),
    .mem_data_inputs(mdin_b), .mem_data_outputs(mdout_b)
  );

  // Memory A: data is valid only in the cycle after the strobe edge.
  always @(posedge clk) begin
    if (mwr_a) mem_a[maddr_a] <= mdin_a;
    if (mrd_a) mdout_a <= mem_a[maddr_a];
    else       mdout_a <= 8'hEE;
  end

  // Memory B: data appears three edges after the strobe edge and then holds.
  always @(posedge clk) begin
    if (mwr_b) mem_b[maddr_b] <= mdin_b;
    if (reset) begin
      pend_b <= 2'd0;
    end else if (mrd_b) begin
      pend_b  <= 2'd2;
      val_b   <= mem_b[maddr_b];
      mdout_b <= 8'hEE;
    end else if (pend_b != 2'd0) begin
      pend_b <= pend_b - 2'd1;
      if (pend_b == 2'd1) mdout_b <= val_b;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_ack(input bit d, input bit p);
    return d ? ack_b[p] : ack_a[p];
  endfunction

  function automatic logic [7:0] get_rdata(input bit d, input bit p);
    return d ? rdata_b[p] : rdata_a[p];
  endfunction

  function automatic logic [1:0] get_strobes(input bit d);
    return d ? {mrd_b, mwr_b} : {mrd_a, mwr_a};
  endfunction

  task automatic drive(input bit d, input bit p, input logic req, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (d) begin
      req_b[p] = req; we_b[p] = we; addr_b[p] = addr; wdata_b[p] = wdata;
    end else begin
      req_a[p] = req; we_a[p] = we; addr_a[p] = addr; wdata_a[p] = wdata;
    end
  endtask

  // Single access on an idle DUT; lat counts edges from the req-sampling edge.
  task automatic run_txn(input bit d, input bit p, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, output int lat, output logic [7:0] rd);
    lat = -1;
    rd  = 8'h00;
    @(negedge clk);
    drive(d, p, 1'b1, we, addr, wdata);
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        check("strobe_issue", get_strobes(d), we ? 2'b01 : 2'b10);
        check("mem_address", d ? maddr_b : maddr_a, addr);
        if (we) check("mem_data_inputs", d ? mdin_b : mdin_a, wdata);
      end
      if (n == 2) check("strobe_cleared", get_strobes(d), 2'b00);
      if (get_ack(d, p)) begin
        lat = n;
        rd  = get_rdata(d, p);
        break;
      end
    end
    drive(d, p, 1'b0, 1'b0, addr, wdata);
    @(posedge clk); #1;
    check("ack_one_cycle", get_ack(d, p), 1'b0);
  endtask

  typedef struct {
    bit         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    int         exp_lat;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] last_rd [2];
  logic [7:0] model [256];
  bit         mvalid [256];

  initial begin
    int         lat, overlap, got, viol;
    logic [7:0] rd;
    bit         exp_port;
    bit         pend [2];
    logic       pwe [2];
    logic [7:0] paddr [2];
    logic [7:0] pwd [2];
    int         age [2];
    int         other [2];

    vecs[0] = '{1'b0, 1'b1, 8'h1F, 8'hA5, 8'h00, 2};
    vecs[1] = '{1'b0, 1'b0, 8'h1F, 8'h00, 8'hA5, 3};
    vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'h7E, 8'h00, 2};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h7E, 3};
    vecs[4] = '{1'b1, 1'b0, 8'h1F, 8'h00, 8'hA5, 3};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 8'h5A, 8'h00, 2};
    vecs[6] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A, 3};

    reset = 1'b1;
    for (int p = 0; p < 2; p++) begin
      drive(1'b0, p[0], 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1'b1, p[0], 1'b0, 1'b0, 8'h00, 8'h00);
      last_rd[p] = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset then idle
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("idle_outputs_a", {ack_a, rdata_a[0], rdata_a[1], busy_a, maddr_a, mrd_a, mwr_a, mdin_a}, 64'd0);
      check("idle_outputs_b", {ack_b, rdata_b[0], rdata_b[1], busy_b, maddr_b, mrd_b, mwr_b, mdin_b}, 64'd0);
    end

    // Directed vectors on the MEM_LAT=1 instance
    foreach (vecs[i]) begin
      run_txn(1'b0, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
      check("vec_latency", lat, vecs[i].exp_lat);
      if (!vecs[i].we) begin
        check("vec_rdata", rd, vecs[i].exp_rdata);
        last_rd[vecs[i].port] = vecs[i].exp_rdata;
      end
      check("vec_other_rdata_held", rdata_a[~vecs[i].port], last_rd[~vecs[i].port]);
    end

    // MEM_LAT=3 instance
    run_txn(1'b1, 1'b0, 1'b1, 8'h20, 8'hC3, lat, rd);
    check("lat3_write_latency", lat, 2);
    run_txn(1'b1, 1'b0, 1'b0, 8'h20, 8'h00, lat, rd);
    check("lat3_read_latency", lat, 5);
    check("lat3_read_rdata", rd, 8'hC3);

    // Simultaneous held requests after reset: port 0 first, then strict alternation
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 8'h3C);
    exp_port = 1'b0; got = 0; overlap = 0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      @(posedge clk); #1;
      if (ack_a == 2'b11) overlap++;
      else if (ack_a != 2'b00) begin
        check("alt_grant_port", ack_a[1], exp_port);
        if (!ack_a[1]) check("alt_rdata0", rdata_a[0], 8'h5A);
        exp_port = ~exp_port;
        got++;
      end
    end
    check("alt_ack_count", got, 5);
    check("alt_no_overlap", overlap, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (5) @(posedge clk);
    run_txn(1'b0, 1'b0, 1'b0, 8'h01, 8'h00, lat, rd);
    check("alt_write_landed", rd, 8'h3C);

    // Reset during WAIT of a port 0 read
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h1F, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midread_busy_before", busy_a, 1'b1);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h1F, 8'h00);
    @(posedge clk); #1;
    check("midread_idle_outputs", {busy_a, mrd_a, mwr_a, ack_a}, 64'd0);
    reset = 1'b0;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack_a != 2'b00 || busy_a) got++;
    end
    check("midread_no_ack", got, 0);

    // Randomized traffic against a transaction-level model
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; age[p] = 0; other[p] = 0;
    end
    for (int a = 0; a < 256; a++) mvalid[a] = 1'b0;
    viol = 0;
    for (int cyc = 0; cyc < 460; cyc++) begin
      @(posedge clk); #1;
      if (ack_a == 2'b11) viol++;
      if (mrd_a && mwr_a) viol++;
      if (cyc >= 400 && !pend[0] && !pend[1]) break;
      for (int p = 0; p < 2; p++) begin
        if (ack_a[p]) begin
          check("rnd_ack_was_pending", pend[p], 1'b1);
          if (pend[p]) begin
            if (pwe[p]) begin
              model[paddr[p]]  = pwd[p];
              mvalid[paddr[p]] = 1'b1;
            end else if (mvalid[paddr[p]]) begin
              check("rnd_rdata", rdata_a[p], model[paddr[p]]);
            end
            check("rnd_fair", other[p] <= 1, 1'b1);
            if (pend[1-p]) other[1-p]++;
            pend[p] = 1'b0;
            req_a[p] = 1'b0;
          end
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (pend[p]) begin
          age[p]++;
          if (age[p] > 30) begin
            check("rnd_timeout", age[p], 0);
            pend[p] = 1'b0;
            req_a[p] = 1'b0;
          end
        end else if (cyc < 400 && $urandom_range(0, 2) == 0) begin
          pwe[p]   = $urandom_range(0, 1) == 1;
          paddr[p] = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
          pwd[p]   = 8'($urandom);
          pend[p]  = 1'b1;
          age[p]   = 0;
          other[p] = 0;
          drive(1'b0, p[0], 1'b1, pwe[p], paddr[p], pwd[p]);
        end
      end
    end
    check("rnd_drained", {pend[0], pend[1]}, 2'b00);
    check("rnd_exclusive_violations", viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
